// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with hold, shift right,
// shift left and parallel load, serial taps at both ends, and a saturating
// shift counter whose terminal value raises Done.
// Optional feature macro: SHREG_ROTATE_EN adds the Rotate input, which feeds
// the outgoing bit back into the vacated end during shifts.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerInMsb,
  input  logic             SerInLsb,
`ifdef SHREG_ROTATE_EN
  input  logic             Rotate,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             SerOutMsb,
  output logic             SerOutLsb,
  output logic [CW-1:0]    Cnt,
  output logic             Done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             msb_in, lsb_in;
  logic             shift;

  // Serial fill bits: rotation recirculates the bit falling off the other end.
`ifdef SHREG_ROTATE_EN
  assign msb_in = Rotate ? q_q[0]       : SerInMsb;
  assign lsb_in = Rotate ? q_q[WIDTH-1] : SerInLsb;
`else
  assign msb_in = SerInMsb;
  assign lsb_in = SerInLsb;
`endif

  // Next-state decode for data and shift counter; every Mode value is legal.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    shift = 1'b0;
    unique case (mode_e'(Mode))
      MODE_HOLD: ;
      MODE_SHR: begin
        q_d   = {msb_in, q_q[WIDTH-1:1]};
        shift = 1'b1;
      end
      MODE_SHL: begin
        q_d   = {q_q[WIDTH-2:0], lsb_in};
        shift = 1'b1;
      end
      MODE_LOAD: begin
        q_d   = D;
        cnt_d = '0;
      end
      default: ;
    endcase
    // Counter saturates at WIDTH while data keeps moving.
    if (shift && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // State registers; reset wins over any clock edge while asserted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q         = q_q;
  assign SerOutMsb = q_q[WIDTH-1];
  assign SerOutLsb = q_q[0];
  assign Cnt       = cnt_q;
  // Done comes only from the counter register, never from inputs.
  assign Done      = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed vectors for univ_shift_reg (WIDTH=8,
// RESET_VAL=8'hA5), checked every cycle against a behavioural model plus
// hand-computed literal expectations.
module tb_univ_shift_reg;
  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [1:0]   Mode = 2'b00;
  logic [W-1:0] D = '0;
  logic         SerInMsb = 1'b0;
  logic         SerInLsb = 1'b0;
  logic         Rotate = 1'b0;
  logic [W-1:0] Q;
  logic         SerOutMsb, SerOutLsb;
  logic [3:0]   Cnt;
  logic         Done;

  int total = 0;
  int bad   = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .Clk(Clk), .Reset(Reset), .Mode(Mode), .D(D),
    .SerInMsb(SerInMsb), .SerInLsb(SerInLsb),
`ifdef SHREG_ROTATE_EN
    .Rotate(Rotate),
`endif
    .Q(Q), .SerOutMsb(SerOutMsb), .SerOutLsb(SerOutLsb),
    .Cnt(Cnt), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: word as an integer, count as a plain saturating int.
  logic [W-1:0] m_q;
  int           m_cnt;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_q   <= RV;
      m_cnt <= 0;
    end else begin
      bit rot;
`ifdef SHREG_ROTATE_EN
      rot = Rotate;
`else
      rot = 1'b0;
`endif
      case (Mode)
        2'd1: begin
          m_q   <= (m_q >> 1) | ((rot ? {7'd0, m_q[0]} : {7'd0, SerInMsb}) << 7);
          m_cnt <= (m_cnt < W) ? m_cnt + 1 : W;
        end
        2'd2: begin
          m_q   <= (m_q << 1) | (rot ? {7'd0, m_q[7]} : {7'd0, SerInLsb});
          m_cnt <= (m_cnt < W) ? m_cnt + 1 : W;
        end
        2'd3: begin
          m_q   <= D;
          m_cnt <= 0;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    chk("cyc_q",    32'(Q),         32'(m_q));
    chk("cyc_smsb", 32'(SerOutMsb), 32'(m_q[W-1]));
    chk("cyc_slsb", 32'(SerOutLsb), 32'(m_q[0]));
    chk("cyc_cnt",  32'(Cnt),       32'(m_cnt));
    chk("cyc_done", 32'(Done),      32'(m_cnt == W));
  end

  // Apply one operation for exactly one posedge; returns 1ns after that edge.
  task automatic op(input logic [1:0] m, input logic [W-1:0] d,
                    input logic sr, input logic sl, input logic rot);
    @(negedge Clk); #1;
    Mode = m; D = d; SerInMsb = sr; SerInLsb = sl; Rotate = rot;
    @(posedge Clk); #1;
  endtask

  initial begin
    int seq [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_q", 32'(Q), 32'h A5);
    chk("rst_cnt", 32'(Cnt), 0);
    chk("rst_done", 32'(Done), 0);
    @(negedge Clk); #1 Reset = 1'b0;

    // Shift right a loaded word out through the LSB tap.
    op(2'b11, 8'b1000_0001, 0, 0, 0);
    chk("shr_lsb0", 32'(SerOutLsb), 32'(seq[0]));
    for (int i = 0; i < 8; i++) begin
      op(2'b01, 8'h00, 0, 0, 0);
      if (i < 7) chk("shr_lsb", 32'(SerOutLsb), 32'(seq[i+1]));
    end
    chk("shr_q", 32'(Q), 32'h00);
    chk("shr_cnt", 32'(Cnt), 8);
    chk("shr_done", 32'(Done), 1);

    // Shift left past saturation.
    op(2'b11, 8'h01, 0, 0, 0);
    chk("ld_done_clr", 32'(Done), 0);
    for (int i = 1; i <= 10; i++) begin
      op(2'b10, 8'h00, 0, 1, 0);
      chk("shl_cnt", 32'(Cnt), (i < 8) ? 32'(i) : 32'd8);
    end
    chk("shl_q", 32'(Q), 32'hFF);
    chk("shl_done", 32'(Done), 1);

    // Hold keeps everything; load clears counter.
    for (int i = 0; i < 3; i++) begin
      op(2'b00, 8'h55, 0, 0, 0);
      chk("hold_q", 32'(Q), 32'hFF);
      chk("hold_cnt", 32'(Cnt), 8);
      chk("hold_done", 32'(Done), 1);
    end
    op(2'b11, 8'h3C, 0, 0, 0);
    chk("rld_q", 32'(Q), 32'h3C);
    chk("rld_cnt", 32'(Cnt), 0);
    chk("rld_done", 32'(Done), 0);

    // Mixed directions share one counter.
    op(2'b10, 8'h00, 0, 1, 0);
    op(2'b01, 8'h00, 1, 0, 0);
    chk("mix_q", 32'(Q), 32'hBC);
    chk("mix_cnt", 32'(Cnt), 2);

    // Reset mid-sequence acts asynchronously and freezes the register.
    op(2'b11, 8'hF0, 0, 0, 0);
    for (int i = 0; i < 3; i++) op(2'b01, 8'h00, 0, 0, 0);
    chk("mid_q", 32'(Q), 32'h1E);
    chk("mid_cnt", 32'(Cnt), 3);
    @(negedge Clk); #2;
    Reset = 1'b1;
    #1;
    chk("arst_q", 32'(Q), 32'hA5);
    chk("arst_cnt", 32'(Cnt), 0);
    chk("arst_done", 32'(Done), 0);
    Mode = 2'b11; D = 8'hFF;
    repeat (2) @(posedge Clk);
    #1;
    chk("rsthold_q", 32'(Q), 32'hA5);
    chk("rsthold_cnt", 32'(Cnt), 0);
    @(negedge Clk); #1;
    Mode = 2'b00; Reset = 1'b0;
    op(2'b10, 8'h00, 0, 0, 0);
    chk("post_rst_q", 32'(Q), 32'h4A);
    chk("post_rst_cnt", 32'(Cnt), 1);

`ifdef SHREG_ROTATE_EN
    op(2'b11, 8'h81, 0, 0, 0);
    for (int i = 0; i < 8; i++) op(2'b01, 8'h00, 0, 0, 1);
    chk("rot_q", 32'(Q), 32'h81);
    chk("rot_done", 32'(Done), 1);
    op(2'b10, 8'h00, 0, 0, 1);
    chk("rotl_q", 32'(Q), 32'h03);
    op(2'b11, 8'h5A, 0, 0, 1);
    chk("rot_ld_q", 32'(Q), 32'h5A);
`endif

    op(2'b00, 8'h00, 0, 0, 0);
    @(negedge Clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
